// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
// Module      : button_events
// Description : Turns a clean button level into press, release, long-press and
//               auto-repeat pulses. Auto-repeat exists only when the macro
//               BUTTON_EVENTS_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module button_events #(
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ibutton,
    output logic press,
    output logic o_release,
    output logic long_press,
    output logic o_repeat,
    output logic held
);

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam logic c_REPEAT_EN = 1'b1;
`else
    localparam logic c_REPEAT_EN = 1'b0;
`endif

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PRESSED = 2'd1;
    localparam logic [1:0] c_ST_LONG    = 2'd2;

    // The press edge loads cnt=1, so the threshold is the full hold length.
    localparam logic [31:0] c_HOLD_LAST   = 32'(HOLD_CYCLES);
    localparam logic [31:0] c_REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [31:0] r_cnt;
    logic        r_press;
    logic        r_release;
    logic        r_long;
    logic        r_repeat;
    logic        r_held;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 32'd0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt  <= 32'd0;
                    r_held <= 1'b0;
                    if (ibutton) begin
                        r_press <= 1'b1;
                        r_held  <= 1'b1;
                        r_state <= c_ST_PRESSED;
                        r_cnt   <= 32'd1;
                    end
                end
                c_ST_PRESSED: begin
                    // Release is tested first so it wins over a coinciding threshold.
                    if (!ibutton) begin
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_state   <= c_ST_IDLE;
                        r_cnt     <= 32'd0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_long  <= 1'b1;
                        r_state <= c_ST_LONG;
                        r_cnt   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_ST_LONG: begin
                    if (!ibutton) begin
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_state   <= c_ST_IDLE;
                        r_cnt     <= 32'd0;
                    end else if (c_REPEAT_EN) begin
                        if (r_cnt == c_REPEAT_LAST) begin
                            r_repeat <= 1'b1;
                            r_cnt    <= 32'd0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end else begin
                        r_cnt <= 32'd0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= 32'd0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign press      = r_press;
    assign o_release  = r_release;
    assign long_press = r_long;
    assign o_repeat   = r_repeat;
    assign held       = r_held;

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_events
// Description : Self-checking bench for button_events against a run-length
//               event model; honours BUTTON_EVENTS_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_events;

    localparam int HOLD = 8;
    localparam int REP  = 4;
`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam int REP_EN = 1;
`else
    localparam int REP_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ibutton = 1'b0;
    logic press, o_release, long_press, o_repeat, held;

    button_events #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst_n(rst_n), .ibutton(ibutton), .press(press),
        .o_release(o_release), .long_press(long_press), .o_repeat(o_repeat), .held(held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: length of the current run of pressed samples since the press edge.
    int run_len = 0;
    int e_press, e_release, e_long, e_repeat, e_held;

    // Per-scenario event log, indexed by output cycle.
    int t;
    int first_press, last_press, first_release, first_long, first_rep, last_rep;
    int n_press, n_release, n_long, n_rep, n_held;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic b, input logic r);
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        if (!r) begin
            run_len = 0;
        end else if (b) begin
            e_press  = (run_len == 0);
            run_len  = run_len + 1;
            e_long   = (run_len == HOLD + 1);
            e_repeat = (REP_EN != 0) && (run_len > HOLD + 1) && (((run_len - HOLD - 1) % REP) == 0);
        end else begin
            e_release = (run_len > 0);
            run_len   = 0;
        end
        e_held = (run_len > 0);
    endtask

    task automatic begin_scn();
        t = 0;
        first_press = -1; last_press = -1; first_release = -1; first_long = -1;
        first_rep = -1; last_rep = -1;
        n_press = 0; n_release = 0; n_long = 0; n_rep = 0; n_held = 0;
    endtask

    task automatic step(input logic b, input logic r);
        ibutton = b;
        rst_n   = r;
        @(posedge clk);
        #1;
        t++;
        model(b, r);
        chk("press", int'(press), e_press);
        chk("release", int'(o_release), e_release);
        chk("long_press", int'(long_press), e_long);
        chk("repeat", int'(o_repeat), e_repeat);
        chk("held", int'(held), e_held);
        if (press) begin n_press++; last_press = t; if (first_press < 0) first_press = t; end
        if (o_release) begin n_release++; if (first_release < 0) first_release = t; end
        if (long_press) begin n_long++; if (first_long < 0) first_long = t; end
        if (o_repeat) begin n_rep++; last_rep = t; if (first_rep < 0) first_rep = t; end
        if (held) n_held++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        begin_scn();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("reset_held", int'(held), 0);
        idle(3);

        // Three-cycle press
        begin_scn();
        for (int i = 0; i < 20; i++) step(i >= 10 && i < 13, 1'b1);
        chk("s1_press_cyc", first_press, 11);
        chk("s1_release_cyc", first_release, 14);
        chk("s1_held_cycles", n_held, 3);
        chk("s1_long_count", n_long, 0);

        // Long hold with possible auto-repeat
        idle(3);
        begin_scn();
        for (int i = 0; i < 50; i++) step(i >= 10 && i < 40, 1'b1);
        chk("s2_press_cyc", first_press, 11);
        chk("s2_long_cyc", first_long, 19);
        chk("s2_release_cyc", first_release, 41);
        chk("s2_rep_count", n_rep, (REP_EN != 0) ? 5 : 0);
        chk("s2_rep_first", first_rep, (REP_EN != 0) ? 23 : -1);
        chk("s2_rep_last", last_rep, (REP_EN != 0) ? 39 : -1);

        // Release lands on the long-press edge
        idle(3);
        begin_scn();
        for (int i = 0; i < 30; i++) step(i >= 10 && i < 18, 1'b1);
        chk("s3_release_cyc", first_release, 19);
        chk("s3_long_count", n_long, 0);
        chk("s3_release_count", n_release, 1);

        // Reset while in LONG with the button still down
        idle(3);
        begin_scn();
        for (int i = 0; i < 30; i++) step(i >= 10, i != 22);
        chk("s4_release_count", n_release, 0);
        chk("s4_press_count", n_press, 2);
        chk("s4_repress_cyc", last_press, 24);
        idle(3);

        // Single-cycle pulse
        idle(3);
        begin_scn();
        for (int i = 0; i < 16; i++) step(i == 10, 1'b1);
        chk("s5_press_cyc", first_press, 11);
        chk("s5_release_cyc", first_release, 12);
        chk("s5_held_cycles", n_held, 1);

        // Random runs of pressed/released levels with occasional resets
        begin_scn();
        for (int n = 0; n < 300; n++) begin
            logic b;
            int len;
            b   = logic'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(HOLD - 2, HOLD + 3 * REP + 2))
                                                : int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) step(b, ($urandom_range(0, 60) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
